// File: rtl/pool_unit_arbiter.sv
// Round-robin sequencer sharing one averaging unit among NREQ pooling requesters:
// clear the unit, feed it four beats, wait out its latency, then return the result.
module pool_unit_arbiter #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 4,
   parameter int DW      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DW-1:0]        rsp_data,
   output logic                 busy,
   output logic                 unit_rst,
   output logic                 unit_en,
   output logic [DW-1:0]        unit_din,
   input  logic [DW-1:0]        unit_avg
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, RESP} state_t;
   state_t state, state_nxt;

   logic [GW-1:0]   grant;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   pick;
   logic            pick_found;
   logic [2:0]      beat_cnt;
   logic [3:0]      lat_cnt;
   logic [NREQ-1:0] grant_onehot;
   logic            beat_ok;

   assign grant_onehot = NREQ'(1) << grant;
   assign beat_ok      = (state == FEED) && req[grant];
   assign req_ready    = (state == FEED) ? grant_onehot : '0;
   assign unit_rst     = (state == CLEAR);
   assign busy         = (state != IDLE);

   // Search starts just above the last served requester, wrapping, so nobody starves.
   always_comb begin
      pick       = last_grant;
      pick_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!pick_found && req[(int'(last_grant) + k) % NREQ]) begin
            pick       = GW'((int'(last_grant) + k) % NREQ);
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_found) state_nxt = CLEAR;
         CLEAR:   state_nxt = FEED;
         FEED:    if (beat_ok && beat_cnt == 3'd3) state_nxt = WAIT;
         WAIT:    if (lat_cnt == 4'(LATENCY)) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // unit_en and rsp_valid default low each cycle; only an accepted beat or the final
   // latency cycle raises them, which gives the one-cycle pulses the unit and requesters expect.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant      <= '0;
         last_grant <= GW'(NREQ - 1);
         beat_cnt   <= '0;
         lat_cnt    <= '0;
         unit_en    <= 1'b0;
         unit_din   <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
      end else begin
         unit_en   <= 1'b0;
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (pick_found) grant <= pick;
            end
            CLEAR: begin
               beat_cnt <= '0;
            end
            FEED: begin
               if (beat_ok) begin
                  unit_din <= req_data[int'(grant)*DW +: DW];
                  unit_en  <= 1'b1;
                  beat_cnt <= beat_cnt + 3'd1;
                  if (beat_cnt == 3'd3) lat_cnt <= 4'd1;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt + 4'd1;
               if (lat_cnt == 4'(LATENCY)) begin
                  rsp_data  <= unit_avg;
                  rsp_valid <= grant_onehot;
               end
            end
            RESP: begin
               last_grant <= grant;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pool_unit_arbiter.sv
// Bench for pool_unit_arbiter: a behavioural averaging unit, per-requester beat drivers,
// and a scoreboard whose expected averages come straight from the window contents.
module tb_pool_unit_arbiter;
   localparam int NREQ    = 4;
   localparam int LATENCY = 4;
   localparam int DW      = 32;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*DW-1:0]   req_data = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      rsp_valid;
   logic [DW-1:0]        rsp_data;
   logic                 busy;
   logic                 unit_rst;
   logic                 unit_en;
   logic [DW-1:0]        unit_din;
   logic [DW-1:0]        unit_avg;

   pool_unit_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .unit_rst(unit_rst),
      .unit_en(unit_en), .unit_din(unit_din), .unit_avg(unit_avg)
   );

   always #5 clk = ~clk;

   // Averaging unit: accumulate on enable, clear on unit_rst, and a two-stage output
   // pipe so the final average appears exactly LATENCY cycles after the last enable.
   logic signed [DW-1:0] acc = '0;
   logic signed [DW-1:0] avg_p1 = '0;
   logic signed [DW-1:0] avg_p2 = '0;
   always @(posedge clk) begin
      if (unit_rst) acc <= '0;
      else if (unit_en) acc <= acc + $signed(unit_din);
      avg_p1 <= acc >>> 2;
      avg_p2 <= avg_p1;
   end
   assign unit_avg = avg_p2;

   typedef struct {
      int              who;
      int              cyc;
      int              gap;
      longint          dat;
      logic [NREQ-1:0] vld;
   } rsp_t;

   logic signed [DW-1:0] beat_q [NREQ][$];
   logic signed [DW-1:0] exp_q  [NREQ][$];
   rsp_t rsp_log[$];
   int vectors = 0;
   int fails = 0;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference model: the expected result is floor(sum/4) of the four beats.
   task automatic applyStimulus(input int who, input int b0, input int b1, input int b2, input int b3);
      longint s;
      s = longint'(b0) + longint'(b1) + longint'(b2) + longint'(b3);
      beat_q[who].push_back(DW'(b0));
      beat_q[who].push_back(DW'(b1));
      beat_q[who].push_back(DW'(b2));
      beat_q[who].push_back(DW'(b3));
      exp_q[who].push_back(DW'(s >>> 2));
   endtask

   // Driver: a requester offers its oldest beat, optionally dropping req at random
   // or for a scripted three-cycle gap after a given accepted beat.
   logic [NREQ-1:0] took;
   int acc_cnt[NREQ];
   int gap_at[NREQ];
   int gap_left[NREQ];
   int drop_pct = 0;
   always begin
      @(negedge clk);
      took = req & req_ready & {NREQ{~rst}};
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (took[i] && beat_q[i].size() > 0) begin
            void'(beat_q[i].pop_front());
            acc_cnt[i]++;
            if (gap_at[i] != 0 && acc_cnt[i] == gap_at[i]) gap_left[i] = 3;
         end
         if (gap_left[i] > 0) begin
            req[i] = 1'b0;
            gap_left[i]--;
         end else if (beat_q[i].size() > 0 && int'($urandom_range(99)) >= drop_pct) begin
            req[i] = 1'b1;
            req_data[i*DW +: DW] = beat_q[i][0];
         end else begin
            req[i] = 1'b0;
         end
      end
   end

   // Monitor: per-window bookkeeping, checked whenever a response pulse appears.
   int cyc = 0;
   int win_en = 0;
   int win_rst = 0;
   int win_gap = 0;
   int last_en_cyc = 0;
   int who;
   logic [NREQ-1:0] win_ready = '0;
   logic held = 1'b0;
   logic [DW-1:0] held_data = '0;
   rsp_t r;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         win_en = 0; win_rst = 0; win_gap = 0; win_ready = '0; held = 1'b0;
      end else begin
         if (held) checkOutput("rsp_data_hold", rsp_data, held_data);
         held = 1'b0;
         if (req_ready != '0) begin
            checkOutput("req_ready_onehot", $countones(req_ready), 1);
            win_ready |= req_ready;
         end
         if (unit_rst) win_rst++;
         if (unit_en) begin
            win_en++;
            last_en_cyc = cyc;
         end else if (win_en > 0 && win_en < 4) begin
            win_gap++;
         end
         if (rsp_valid != '0) begin
            checkOutput("rsp_valid_onehot", $countones(rsp_valid), 1);
            who = 0;
            for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) who = i;
            if (exp_q[who].size() == 0) begin
               vectors++;
               fails++;
               $display("[TB] FAIL rsp_unexpected: requester %0d got %0d, no window open", who, $signed(rsp_data));
            end else begin
               checkOutput($sformatf("rsp_data[%0d]", who), $signed(rsp_data), exp_q[who].pop_front());
            end
            checkOutput("ready_mask_vs_rsp", win_ready, rsp_valid);
            checkOutput("unit_en_cycles", win_en, 4);
            checkOutput("unit_rst_pulses", win_rst, 1);
            checkOutput("latency_after_last_en", cyc - last_en_cyc, LATENCY);
            r.who = who; r.cyc = cyc; r.gap = win_gap; r.dat = $signed(rsp_data); r.vld = rsp_valid;
            rsp_log.push_back(r);
            win_en = 0; win_rst = 0; win_gap = 0; win_ready = '0;
            held = 1'b1;
            held_data = rsp_data;
         end
      end
   end

   function automatic rsp_t logAt(input int idx);
      rsp_t e;
      e.who = -1; e.cyc = -1; e.gap = -1; e.dat = -999999; e.vld = '0;
      if (idx < rsp_log.size()) e = rsp_log[idx];
      return e;
   endfunction

   function automatic int outstanding();
      int s = 0;
      for (int i = 0; i < NREQ; i++) s += exp_q[i].size() + beat_q[i].size();
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_req_ready"}, req_ready, 0);
      checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
      checkOutput({tag, "_rsp_data"}, rsp_data, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_unit_rst"}, unit_rst, 0);
      checkOutput({tag, "_unit_en"}, unit_en, 0);
      checkOutput({tag, "_unit_din"}, unit_din, 0);
   endtask

   task automatic doReset();
      tick();
      rst = 1'b1;
      req = '0;
      for (int i = 0; i < NREQ; i++) begin
         beat_q[i].delete();
         exp_q[i].delete();
         acc_cnt[i] = 0; gap_at[i] = 0; gap_left[i] = 0;
      end
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int n = 0;
      while ((outstanding() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_drained"}, longint'(n < budget), 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int base;
      int n;
      int order2[5];
      int d[4];
      order2 = '{0, 1, 2, 3, 0};

      repeat (3) tick();
      checkAllZero("reset");
      rst = 1'b0;

      // Single requester, back-to-back beats.
      tick();
      base = rsp_log.size();
      applyStimulus(0, 4, 8, 12, 16);
      waitDrain("t1", 200);
      checkOutput("t1_count", rsp_log.size() - base, 1);
      checkOutput("t1_valid", logAt(base).vld, 4'b0001);
      checkOutput("t1_data", logAt(base).dat, 10);

      // All four requesters at once: grants rotate 0,1,2,3,0 at full throughput.
      doReset();
      base = rsp_log.size();
      applyStimulus(0, 1, 2, 3, 4);
      applyStimulus(0, 50, 60, 70, 80);
      applyStimulus(1, 20, 20, 20, 24);
      applyStimulus(2, -100, 0, 0, 0);
      applyStimulus(3, 9, 9, 9, 9);
      waitDrain("t2", 400);
      for (int k = 0; k < 5; k++) checkOutput($sformatf("t2_grant%0d", k), logAt(base + k).who, order2[k]);
      for (int k = 1; k < 5; k++)
         checkOutput($sformatf("t2_spacing%0d", k), logAt(base + k).cyc - logAt(base + k - 1).cyc, 7 + LATENCY);

      // req1 pauses three cycles after its second beat while req2 waits.
      tick();
      base = rsp_log.size();
      gap_at[1] = acc_cnt[1] + 2;
      applyStimulus(1, 100, 200, 300, 400);
      applyStimulus(2, 1000, 1000, 1000, 1000);
      waitDrain("t3", 300);
      gap_at[1] = 0;
      checkOutput("t3_first", logAt(base).who, 1);
      checkOutput("t3_en_gap", logAt(base).gap, 3);
      checkOutput("t3_data", logAt(base).dat, 250);
      checkOutput("t3_second", logAt(base + 1).who, 2);

      // Negative operands pass through as signed.
      tick();
      base = rsp_log.size();
      applyStimulus(0, -8, -4, 0, 4);
      waitDrain("t4", 200);
      checkOutput("t4_who", logAt(base).who, 0);
      checkOutput("t4_data", logAt(base).dat, -2);

      // Reset while waiting on the unit aborts the window silently.
      tick();
      base = rsp_log.size();
      applyStimulus(1, 10, 20, 30, 40);
      n = 0;
      while (beat_q[1].size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t5_reached_wait", longint'(n < 50), 1);
      tick();
      rst = 1'b1;
      exp_q[1].delete();
      tick();
      checkAllZero("t5_abort");
      rst = 1'b0;
      repeat (20) tick();
      checkOutput("t5_no_rsp", rsp_log.size() - base, 0);
      applyStimulus(2, 1, 2, 3, 6);
      waitDrain("t5", 200);
      checkOutput("t5_valid", logAt(base).vld, 4'b0100);
      checkOutput("t5_data", logAt(base).dat, 3);

      // After req3 is served, req0 outranks req3.
      doReset();
      base = rsp_log.size();
      applyStimulus(3, 7, 7, 7, 7);
      waitDrain("t6a", 200);
      tick();
      applyStimulus(0, 0, 4, 8, 12);
      applyStimulus(3, 100, 100, 100, 104);
      waitDrain("t6b", 300);
      checkOutput("t6_first", logAt(base).who, 3);
      checkOutput("t6_second", logAt(base + 1).who, 0);
      checkOutput("t6_third", logAt(base + 2).who, 3);
      checkOutput("t6_data", logAt(base + 2).dat, 101);

      // Random windows from random requesters with random req drops.
      tick();
      base = rsp_log.size();
      drop_pct = 25;
      for (int k = 0; k < 40; k++) begin
         for (int j = 0; j < 4; j++) d[j] = int'($urandom_range(0, 32'h2000_0000)) - 32'h1000_0000;
         applyStimulus(int'($urandom_range(NREQ - 1)), d[0], d[1], d[2], d[3]);
         if ($urandom_range(3) == 0) repeat ($urandom_range(1, 15)) tick();
      end
      waitDrain("rand", 6000);
      checkOutput("rand_count", rsp_log.size() - base, 40);
      drop_pct = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got %0d checks, expected completion", vectors);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
